data_bus_master: RTL and testbench

DATA_BUS_MASTER -- requirements
Module: data_bus_master

---
 rtl/data_bus_master.sv | 202 ++++++++++++++++++++
 tb/tb_data_bus_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_master.sv
// data_bus_master
//   Turns single load/store requests from a pipeline into word-aligned bus
//   transfers with byte enables. Store data is replicated across byte lanes.
//   Load data is extracted from the addressed lanes and then sign- or
//   zero-extended. Misaligned accesses and the reserved size are answered
//   with an error and never reach the bus. A transfer that stalls for
//   WAIT_TIMEOUT consecutive cycles is aborted with an error.
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   req_*                request channel (valid/ready handshake)
//   resp_*               one-cycle response pulse, no backpressure
//   data_*               bus master side: address, read/write strobes,
//                        byte enables, write data, waitrequest, read data
module data_bus_master #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  output logic [3:0]  data_byteenable,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata
);

  // Wide enough to hold WAIT_TIMEOUT-1 and never zero bits wide
  localparam int CW = $clog2(WAIT_TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Decode the incoming request: legality, lane mask and replicated data
  always_comb begin
    req_legal = 1'b0;
    req_be    = 4'b0000;
    req_wd    = req_wdata;
    case (req_size)
      2'b00: begin
        req_legal = 1'b1;
        req_be    = 4'b0001 << req_addr[1:0];
        req_wd    = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_legal = ~req_addr[0];
        req_be    = 4'b0011 << req_addr[1:0];
        req_wd    = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_legal = (req_addr[1:0] == 2'b00);
        req_be    = 4'b1111;
        req_wd    = req_wdata;
      end
      default: begin
        req_legal = 1'b0;
        req_be    = 4'b0000;
        req_wd    = req_wdata;
      end
    endcase
  end

  // Little-endian lane extraction followed by sign or zero extension
  always_comb begin
    lane      = data_readdata >> {addr_lo_q, 3'b000};
    load_data = lane;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & lane[7]}}, lane[7:0]};
      2'b01:   load_data = {{16{signed_q & lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Next-state logic. An errored request skips ACCESS, so it never strobes
  // the bus. A timeout fires on the stall edge that would bring the counter
  // to WAIT_TIMEOUT.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_lo_d   = addr_lo_q;
    be_d        = be_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    rdata_d     = rdata_q;
    error_d     = error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          signed_d   = req_signed;
          addr_lo_d  = req_addr[1:0];
          rdata_d    = 32'd0;
          wait_cnt_d = '0;
          if (req_legal) begin
            state_d     = ACCESS;
            error_d     = 1'b0;
            be_d        = req_be;
            address_d   = {req_addr[31:2], 2'b00};
            writedata_d = req_wd;
          end else begin
            state_d = RESP;
            error_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!data_waitrequest) begin
          rdata_d = write_q ? 32'd0 : load_data;
          state_d = RESP;
        end else if (wait_cnt_q == CW'(WAIT_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_lo_q   <= 2'b00;
      be_q        <= 4'b0000;
      address_q   <= 32'd0;
      writedata_q <= 32'd0;
      rdata_q     <= 32'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_lo_q   <= addr_lo_d;
      be_q        <= be_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      rdata_q     <= rdata_d;
      error_q     <= error_d;
    end
  end

  // Strobes and enables follow the state directly, so a reset drops them
  // in the same instant it forces the state back to IDLE
  assign req_ready       = (state_q == IDLE);
  assign data_read       = (state_q == ACCESS) && !write_q;
  assign data_write      = (state_q == ACCESS) && write_q;
  assign data_byteenable = (state_q == ACCESS) ? be_q : 4'b0000;
  assign data_address    = address_q;
  assign data_writedata  = writedata_q;
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = (state_q == RESP) ? rdata_q : 32'd0;
  assign resp_error      = (state_q == RESP) && error_q;

endmodule

// File: tb/tb_data_bus_master.sv
// tb_data_bus_master
//   Directed and random load/store transactions against data_bus_master.
//   The DUT is built with a short timeout. Expected lane masks, replicated
//   write data and extended read data come from plain arithmetic helpers.
module tb_data_bus_master;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic        data_waitrequest;
  logic [31:0] data_readdata;

  int checks = 0;
  int errors = 0;

  data_bus_master #(.WAIT_TIMEOUT(TB_TIMEOUT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .data_address     (data_address),
    .data_read        (data_read),
    .data_write       (data_write),
    .data_writedata   (data_writedata),
    .data_byteenable  (data_byteenable),
    .data_waitrequest (data_waitrequest),
    .data_readdata    (data_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte count of an access is 2**size; the mask is that many ones shifted
  // up to the byte offset
  function automatic logic [3:0] expBe(input logic [1:0] sz, input logic [1:0] a);
    int n;
    int m;
    n = 1 << sz;
    m = ((1 << n) - 1) << a;
    return m[3:0];
  endfunction

  // Each of the four bus bytes repeats the store byte at (lane mod size)
  function automatic logic [31:0] expWdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = 1 << sz;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  // Shift the addressed byte to the bottom, keep 8*n bits, then reinterpret
  // as a two's-complement number when the load is signed
  function automatic logic [31:0] expRdata(input logic [1:0] sz, input logic sg,
                                           input logic [1:0] a, input logic [31:0] rd);
    longint bits;
    longint v;
    bits = 8 * (1 << sz);
    v = longint'(rd) >> (8 * a);
    v = v % (64'sd1 << bits);
    if (sg && v >= (64'sd1 << (bits - 1))) v = v - (64'sd1 << bits);
    return v[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete transaction. stall is the number of cycles the slave
  // holds waitrequest; rd is what it returns on the completing edge.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int stall);
    int n;
    int cycles;
    logic legal;
    logic timeout;
    n = 1 << sz;
    legal = (sz != 2'd3) && ((addr % n) == 0);
    @(negedge clk);
    checkBit("ready_idle", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (!legal) begin
      checkBit("err_no_read", data_read, 1'b0);
      checkBit("err_no_write", data_write, 1'b0);
      checkOutput("err_no_be", {28'd0, data_byteenable}, 32'd0);
      checkBit("err_resp_valid", resp_valid, 1'b1);
      checkBit("err_resp_error", resp_error, 1'b1);
      checkOutput("err_rdata", resp_rdata, 32'd0);
    end else begin
      timeout = (stall >= TB_TIMEOUT);
      cycles  = timeout ? TB_TIMEOUT : stall + 1;
      for (int k = 0; k < cycles; k++) begin
        if (k > 0) @(negedge clk);
        data_waitrequest = (k < stall);
        data_readdata    = (k < stall) ? $urandom : rd;
        checkBit("bus_read", data_read, !wr);
        checkBit("bus_write", data_write, wr);
        checkOutput("bus_be", {28'd0, data_byteenable}, {28'd0, expBe(sz, addr[1:0])});
        checkOutput("bus_addr", data_address, addr & 32'hFFFF_FFFC);
        if (wr) checkOutput("bus_wdata", data_writedata, expWdata(sz, wd));
        checkBit("bus_no_resp", resp_valid, 1'b0);
        checkBit("bus_not_ready", req_ready, 1'b0);
      end
      @(negedge clk);
      data_waitrequest = 1'b0;
      data_readdata    = $urandom;
      checkBit("resp_valid", resp_valid, 1'b1);
      checkBit("resp_error", resp_error, timeout);
      checkOutput("resp_rdata", resp_rdata,
                  (timeout || wr) ? 32'd0 : expRdata(sz, sg, addr[1:0], rd));
      checkBit("resp_no_read", data_read, 1'b0);
      checkBit("resp_no_write", data_write, 1'b0);
      checkOutput("resp_no_be", {28'd0, data_byteenable}, 32'd0);
    end
    @(negedge clk);
    checkBit("resp_one_cycle", resp_valid, 1'b0);
    checkOutput("idle_rdata", resp_rdata, 32'd0);
    checkBit("idle_error", resp_error, 1'b0);
    checkBit("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    int          n;

    reset_n          = 1'b0;
    req_valid        = 1'b0;
    req_write        = 1'b0;
    req_size         = 2'b00;
    req_signed       = 1'b0;
    req_addr         = 32'd0;
    req_wdata        = 32'd0;
    data_waitrequest = 1'b0;
    data_readdata    = 32'd0;

    #2;
    checkBit("rst_ready", req_ready, 1'b1);
    checkBit("rst_read", data_read, 1'b0);
    checkBit("rst_write", data_write, 1'b0);
    checkOutput("rst_be", {28'd0, data_byteenable}, 32'd0);
    checkOutput("rst_addr", data_address, 32'd0);
    checkOutput("rst_wdata", data_writedata, 32'd0);
    checkBit("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_rdata", resp_rdata, 32'd0);
    checkBit("rst_resp_error", resp_error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed transactions");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, 0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0, 32'h80FF_7F01, 0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0, 32'h80FF_7F01, 0);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'hCAFE_BEEF, 32'd0, 0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 32'h8001_1234, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h1111_2222, 32'd0, 0);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 32'h5555_5555, 0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 32'hA5A5_0F0F, 3);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h0000_0041, 32'h0000_00C3, 32'd0, 3);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'd0, 32'h7777_7777, 10);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0084, 32'h0BAD_F00D, 32'd0, TB_TIMEOUT);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0090, 32'd0, 32'h1234_56FE, TB_TIMEOUT - 1);

    $display("[TB] reset during a stalled access");
    @(negedge clk);
    req_valid        = 1'b1;
    req_write        = 1'b0;
    req_size         = 2'd2;
    req_signed       = 1'b0;
    req_addr         = 32'h0000_0020;
    data_waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkBit("mid_read_active", data_read, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkBit("mid_rst_read", data_read, 1'b0);
    checkOutput("mid_rst_be", {28'd0, data_byteenable}, 32'd0);
    checkOutput("mid_rst_addr", data_address, 32'd0);
    checkBit("mid_rst_resp", resp_valid, 1'b0);
    @(negedge clk);
    reset_n          = 1'b1;
    data_waitrequest = 1'b0;
    #1;
    checkBit("mid_rel_ready", req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit("mid_no_resp", resp_valid, 1'b0);
      checkBit("mid_no_read", data_read, 1'b0);
    end

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      n    = 1 << sz;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) addr = addr & ~(32'(n) - 32'd1);
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                    $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
